// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO for the MIPS execute stage.
// The result is computed when the operation starts and written to HI/LO when the busy count runs out.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_en,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MULT_CYCLES <= 15 && DIV_CYCLES <= 15) ? 4 : $clog2(MAX_CYCLES) + 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        hi_q, lo_q, hi_pend_q, lo_pend_q;
  logic               div0_q;

  logic               is_mult, is_div, is_signed;
  logic [63:0]        a_ext, b_ext, prod;
  logic               a_neg, b_neg;
  logic [31:0]        a_mag, b_mag, uq, ur, quot, rem;

  assign is_mult   = (md_op[2:1] == 2'b00);
  assign is_div    = (md_op[2:1] == 2'b01);
  assign is_signed = ~md_op[0];

  // Sign- or zero-extending to 64 bits makes the low 64 product bits correct for both mult and multu.
  assign a_ext = {{32{is_signed & A[31]}}, A};
  assign b_ext = {{32{is_signed & B[31]}}, B};
  assign prod  = a_ext * b_ext;

  // Signed divide via magnitudes; 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
  assign a_neg = is_signed & A[31];
  assign b_neg = is_signed & B[31];
  assign a_mag = a_neg ? (~A + 32'd1) : A;
  assign b_mag = b_neg ? (~B + 32'd1) : B;
  assign uq    = a_mag / b_mag;
  assign ur    = a_mag % b_mag;
  assign quot  = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
  assign rem   = a_neg ? (~ur + 32'd1) : ur;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_pend_q <= '0;
      lo_pend_q <= '0;
      div0_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (md_en) begin
            if (is_mult || is_div) begin
              hi_pend_q <= is_mult ? prod[63:32] : rem;
              lo_pend_q <= is_mult ? prod[31:0]  : quot;
              div0_q    <= is_div && (B == 32'd0);
              cnt_q     <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              state_q   <= S_BUSY;
            end else if (md_op == 3'b100) begin
              hi_q <= A;
            end else if (md_op == 3'b101) begin
              lo_q <= A;
            end
          end
        end
        S_BUSY: begin
          // Requests arriving while busy are a protocol violation and are dropped.
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            if (!div0_q) begin
              hi_q <= hi_pend_q;
              lo_q <= lo_pend_q;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q == S_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit that sits beside the ALU in the execute stage of the MIPS datapath. It consumes the two GRF read operands (rs, rt) and holds the architectural HI/LO registers. Those registers feed the write-back mux for mfhi/mflo. Multi-cycle mult/div operations are modelled with a busy counter, and control upstream stalls on `busy`.

## Interface
- `MULT_CYCLES`, default 5: busy duration of mult/multu in cycles. Must be ≥1.
- `DIV_CYCLES`, default 10: busy duration of div/divu in cycles. Must be ≥1.

- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `md_en` in 1: operation request, sampled on the rising edge.
- `md_op` in 3: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo. 110/111 are no-ops.
- `A` in 32: rs operand (dividend / multiplicand / mthi-mtlo data).
- `B` in 32: rt operand (divisor / multiplier).
- `busy` out 1: an operation is in progress.
- `hi` out 32: architectural HI.
- `lo` out 32: architectural LO.

## Operation
- There are two states: IDLE and BUSY. An internal counter `cnt` is 4 bits wide when both parameters are ≤15; otherwise it is sized as clog2(max)+1.
- In IDLE, with `md_en`=1 and a mult or div op:
  - Compute the result from A/B at that edge and latch it into the internal `hi_pend`/`lo_pend` registers.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - Enter BUSY.
- In IDLE, with `md_en`=1 and mthi/mtlo: write A into `hi`/`lo` at that edge. The state stays IDLE and `busy` stays 0.
- In IDLE, with op 110/111 or `md_en`=0: no change.
- In BUSY, each edge decrements `cnt`. On the edge where `cnt` goes 1→0:
  - `hi`←`hi_pend` and `lo`←`lo_pend`.
  - Return to IDLE.
- In BUSY, any `md_en` (including mthi/mtlo) is ignored. Control must stall on `busy | (md_en & op is mult/div)`, so this case is a protocol violation and must not corrupt state.
- Arithmetic rules:
  - mult: signed 32×32→64. `hi`=[63:32], `lo`=[31:0].
  - multu: unsigned 32×32→64, split the same way.
  - div: signed. `lo`=quotient, truncated toward zero. `hi`=remainder, with the sign of the dividend. For 0x80000000 / -1: `lo`=0x80000000, `hi`=0.
  - divu: unsigned. `lo`=quotient, `hi`=remainder.
  - Divide by zero (B=0, div or divu): the unit goes BUSY for the full DIV_CYCLES, but `hi`/`lo` are left unchanged at completion.
- `hi`, `lo` and `busy` are register outputs, with no combinational path from the inputs.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `cnt`=0, state IDLE. `hi_pend`/`lo_pend` also reset to 0.
- Reset has priority over every other event, including mid-operation. A pending result is discarded.
- Start sampled at edge E0 → `busy`=1 from E0 to E_N, i.e. for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- `busy` is 0 after E_N, and the new `hi`/`lo` are visible in the same cycle that `busy` is 0.
- Back-to-back issue: a new start is accepted at E_N+1 at the earliest (the first edge with `busy`=0 sampled). Start at E_N itself is ignored because `busy` was still 1 before that edge.
- mthi/mtlo latency: 1 edge. The value is visible in the cycle after the request.
- mfhi/mflo read `hi`/`lo` directly. Control stalls them while `busy`=1.

## Test plan
- Reset, then mult with A=0xFFFFFFFF (−1), B=2 → `busy` high for exactly 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
- multu with A=0xFFFFFFFF, B=2 → `hi`=0x00000001, `lo`=0xFFFFFFFE after 5 busy cycles.
- div with A=−7 (0xFFFFFFF9), B=2 → `busy` for 10 cycles; `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1).
- divu with A=7, B=0 after mthi 0x1234 / mtlo 0x5678 → each mthi/mtlo is visible after 1 edge with `busy`=0. The divide holds `busy` for 10 cycles and leaves `hi`=0x1234, `lo`=0x5678.
- Start mult, then assert `md_en` with mtlo 0xDEAD on cycle 2 of busy → the request is ignored; the final `lo` is the product. A second mult issued on the first cycle with `busy`=0 is accepted.
- Start div, assert `reset` on cycle 4 of busy → next cycle `busy`=0, `hi`=`lo`=0. No late write-back occurs afterwards.
